// File: rtl/dmem_rr_responder_pkg.sv
// Shared constants and small types for the four-core data-memory responder.
package dmem_pkg;
    localparam int NCORE  = 4;
    localparam int ADDR_W = 12;
    localparam int BUS_W  = 17;
    localparam int DATA_W = 12;
    localparam int DEPTH  = 4096;
    localparam int NTAP   = 16;

    typedef logic [1:0] core_idx_t;

    // Where the registered read data comes from in the return cycle.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_TAP  = 2'd1,
        SRC_MEM  = 2'd2
    } rd_src_t;
endpackage

// File: rtl/dmem_rr_responder_rr_arbiter4.sv
// Combinational four-way round-robin arbiter; search starts at ptr and wraps.
module rr_arbiter4
    import dmem_pkg::*;
(
    input  logic [NCORE-1:0] req,
    input  core_idx_t        ptr,
    output logic [NCORE-1:0] gnt,
    output core_idx_t        win
);
    core_idx_t cand;
    logic      found;

    always_comb begin
        gnt   = '0;
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int i = 0; i < NCORE; i++) begin
            cand = ptr + core_idx_t'(i);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win       = cand;
                gnt[cand] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmem_rr_responder.sv
// Round-robin shared data memory: one access per cycle, registered read return,
// low words held in resettable tap registers that shadow the array.
module dmem_rr_responder #(
    parameter int NCORE  = dmem_pkg::NCORE,
    parameter int ADDR_W = dmem_pkg::ADDR_W,
    parameter int BUS_W  = dmem_pkg::BUS_W,
    parameter int DATA_W = dmem_pkg::DATA_W,
    parameter int DEPTH  = dmem_pkg::DEPTH,
    parameter int NTAP   = dmem_pkg::NTAP
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCORE-1:0]         req,
    input  logic [NCORE-1:0]         we,
    input  logic [NCORE*ADDR_W-1:0]  addr,
    input  logic [NCORE*BUS_W-1:0]   wdata,
    output logic [NCORE-1:0]         gnt,
    output logic [NCORE-1:0]         rvalid,
    output logic [DATA_W-1:0]        rdata,
    output logic [NTAP*DATA_W-1:0]   taps
);
    import dmem_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAP_W = $clog2(NTAP);

    logic [NCORE-1:0]  arb_gnt;
    core_idx_t         win;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we, any_gnt, in_range, is_tap;
    logic              mem_we, mem_re, tap_we;

    core_idx_t         ptr_q, ptr_d, win_q;
    logic              valid_q, valid_d;
    rd_src_t           src_q, src_d;
    logic [DATA_W-1:0] tap_rd_q, tap_rd_d;
    logic [DATA_W-1:0] mem_rd_q;
    logic [DATA_W-1:0] tap_q [NTAP];
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              unused_wdata_hi;

    rr_arbiter4 u_arb (
        .req (req),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .win (win)
    );

    assign gnt     = rst ? '0 : arb_gnt;
    assign any_gnt = |gnt;

    assign sel_addr  = addr[win*ADDR_W +: ADDR_W];
    assign sel_wdata = wdata[win*BUS_W +: DATA_W];
    assign sel_we    = we[win];
    assign in_range  = 32'(sel_addr) < DEPTH;
    assign is_tap    = 32'(sel_addr) < NTAP;
    assign unused_wdata_hi = ^wdata;

    // Tap words live only in the tap registers; the array never sees them.
    assign mem_we = any_gnt &  sel_we & in_range & ~is_tap;
    assign mem_re = any_gnt & ~sel_we & in_range & ~is_tap;
    assign tap_we = any_gnt &  sel_we & is_tap;

    assign ptr_d   = any_gnt ? win + 2'd1 : ptr_q;
    assign valid_d = any_gnt & ~sel_we;

    always_comb begin
        src_d    = src_q;
        tap_rd_d = tap_rd_q;
        if (valid_d) begin
            if (is_tap) begin
                src_d    = SRC_TAP;
                tap_rd_d = tap_q[sel_addr[TAP_W-1:0]];
            end else if (in_range) begin
                src_d = SRC_MEM;
            end else begin
                src_d = SRC_ZERO;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[sel_addr[IDX_W-1:0]] <= sel_wdata;
        if (mem_re) mem_rd_q <= mem_q[sel_addr[IDX_W-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q    <= '0;
            win_q    <= '0;
            valid_q  <= 1'b0;
            src_q    <= SRC_ZERO;
            tap_rd_q <= '0;
            for (int k = 0; k < NTAP; k++) tap_q[k] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            win_q    <= win;
            valid_q  <= valid_d;
            src_q    <= src_d;
            tap_rd_q <= tap_rd_d;
            if (tap_we) tap_q[sel_addr[TAP_W-1:0]] <= sel_wdata;
        end
    end

    // rdata holds between returns because the source registers only move on reads.
    always_comb begin
        case (src_q)
            SRC_TAP: rdata = tap_rd_q;
            SRC_MEM: rdata = mem_rd_q;
            default: rdata = '0;
        endcase
    end

    assign rvalid = valid_q ? (NCORE'(1) << win_q) : '0;

    for (genvar k = 0; k < NTAP; k++) begin : g_taps
        assign taps[k*DATA_W +: DATA_W] = tap_q[k];
    end
endmodule

// File: tb/tb_dmem_rr_responder.sv
// Scoreboard bench for dmem_rr_responder with a shrunken array (DEPTH=64).
module tb_dmem_rr_responder;
    import dmem_pkg::*;

    localparam int TDEPTH = 64;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NCORE-1:0]        req, we, gnt, rvalid;
    logic [NCORE*ADDR_W-1:0] addr;
    logic [NCORE*BUS_W-1:0]  wdata;
    logic [DATA_W-1:0]       rdata;
    logic [NTAP*DATA_W-1:0]  taps;

    always #5 clk = ~clk;

    dmem_rr_responder #(.DEPTH(TDEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .gnt    (gnt),
        .rvalid (rvalid),
        .rdata  (rdata),
        .taps   (taps)
    );

    typedef struct {
        int                core;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    rd_exp_t           sb[$];
    int                m_ptr;
    logic [DATA_W-1:0] m_mem [TDEPTH];
    logic [DATA_W-1:0] m_tap [NTAP];
    int                n_checks = 0;
    int                n_errors = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [NTAP*DATA_W-1:0] model_taps();
        logic [NTAP*DATA_W-1:0] t;
        for (int k = 0; k < NTAP; k++) t[k*DATA_W +: DATA_W] = m_tap[k];
        return t;
    endfunction

    task automatic clr();
        req = '0; we = '0; addr = '0; wdata = '0;
    endtask

    task automatic set_core(input int c, input bit r, input bit w, input int a, input int d);
        req[c] = r;
        we[c]  = w;
        addr[c*ADDR_W +: ADDR_W] = ADDR_W'(a);
        wdata[c*BUS_W +: BUS_W]  = BUS_W'(d);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        sb.delete();
        for (int k = 0; k < NTAP; k++) m_tap[k] = '0;
    endtask

    task automatic check_return();
        rd_exp_t e;
        logic [NCORE-1:0] ev;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            ev = '0;
            ev[e.core] = 1'b1;
            chk("rvalid", rvalid, ev);
            chk("rdata", rdata, e.data);
        end else begin
            chk("rvalid_idle", rvalid, '0);
        end
        chk("taps", taps, model_taps());
    endtask

    // Inputs must already be set; checks the grant, updates the model, crosses one edge.
    task automatic step();
        int g = -1;
        int a;
        rd_exp_t e;
        logic [NCORE-1:0] eg = '0;
        #1;
        for (int i = 0; i < NCORE; i++) begin
            int c = (m_ptr + i) % NCORE;
            if (g < 0 && req[c]) g = c;
        end
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", gnt, eg);
        if (g >= 0) begin
            a = int'(addr[g*ADDR_W +: ADDR_W]);
            if (we[g]) begin
                if (a < NTAP) m_tap[a] = wdata[g*BUS_W +: DATA_W];
                else if (a < TDEPTH) m_mem[a] = wdata[g*BUS_W +: DATA_W];
            end else begin
                e.core = g;
                if (a >= TDEPTH)   e.data = '0;
                else if (a < NTAP) e.data = m_tap[a];
                else               e.data = m_mem[a];
                sb.push_back(e);
            end
            m_ptr = (g + 1) % NCORE;
        end
        @(posedge clk);
        #1;
        check_return();
    endtask

    initial begin
        logic [NCORE-1:0] fg;
        rst = 1'b1;
        clr();
        req = '1;
        model_reset();
        #1;
        chk("gnt_in_reset", gnt, '0);
        @(posedge clk);
        #1;
        chk("rvalid_reset", rvalid, '0);
        chk("rdata_reset", rdata, '0);
        chk("taps_reset", taps, '0);
        @(negedge clk);
        rst = 1'b0;
        clr();

        // single read of an untouched tap word
        set_core(0, 1, 0, 5, 0); step();
        clr(); step();

        // write a tap word with a wide bus value, then read it straight back
        set_core(2, 1, 1, 3, 'h1ABC); step();
        chk("tap3", taps[3*DATA_W +: DATA_W], 12'hABC);
        clr(); set_core(0, 1, 0, 3, 0); step();
        chk("rdata_tap3", rdata, 12'hABC);
        clr(); step();

        // bring ptr to 0, then all four read continuously
        set_core(3, 1, 0, 0, 0); step();
        clr();
        for (int c = 0; c < NCORE; c++) set_core(c, 1, 0, 3, 0);
        for (int k = 0; k < 8; k++) begin
            fg = '0;
            fg[k % NCORE] = 1'b1;
            #1 chk("fair_order", gnt, fg);
            step();
        end
        clr(); set_core(0, 1, 0, 0, 0); step();
        clr(); step();

        // pointer skip: ptr=2 with only cores 0 and 1 requesting
        set_core(1, 1, 0, 0, 0); step();
        clr(); set_core(0, 1, 0, 1, 0); set_core(1, 1, 0, 2, 0);
        #1 chk("skip_first", gnt, 4'b0001);
        step();
        #1 chk("skip_second", gnt, 4'b0010);
        step();
        clr(); step();

        // array word, visible to a read in the very next cycle
        set_core(1, 1, 1, 40, 'h777); step();
        clr(); set_core(2, 1, 0, 40, 0); step();
        clr(); step();

        // out of range write discarded, read returns zero
        set_core(1, 1, 1, 100, 'h555); step();
        clr(); set_core(1, 1, 0, 100, 0); step();
        chk("rdata_oor", rdata, '0);
        clr(); step();

        for (int a = 40; a < 48; a++) begin
            clr(); set_core(a % NCORE, 1, 1, a, int'($urandom_range(0, 'h1FFFF))); step();
        end

        for (int n = 0; n < 60; n++) begin
            clr();
            for (int c = 0; c < NCORE; c++) begin
                int sel = int'($urandom_range(0, 2));
                int a   = (sel == 0) ? int'($urandom_range(0, 15)) :
                          (sel == 1) ? 40 + int'($urandom_range(0, 7)) : 100;
                set_core(c, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                         a, int'($urandom_range(0, 'h1FFFF)));
            end
            step();
        end
        clr(); step(); step();

        // reset between the grant and the return of a read
        set_core(3, 1, 0, 3, 0);
        #1 chk("gnt_pre_rst", gnt, 4'b1000);
        rst = 1'b1;
        #1 chk("gnt_rst_gate", gnt, '0);
        @(posedge clk);
        #1;
        chk("rvalid_after_rst", rvalid, '0);
        chk("taps_after_rst", taps, '0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        clr();
        for (int c = 0; c < NCORE; c++) set_core(c, 1, 0, 40, 0);
        #1 chk("gnt_post_rst", gnt, 4'b0001);
        step();
        clr(); step(); step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_rr_responder.md
# dmem_rr_responder

Shared data-memory responder for the four-core array. Each core acts as an initiator issuing single-word read/write requests. This block arbitrates them round-robin onto one single-ported storage array and returns read data with a registered valid pulse. It replaces the free-for-all four-port data memory, with the same 16-word debug tap toward the top level.

## Interface

Parameters:
- NCORE, 4, number of requesting cores (fixed at 4; arbiter is sized for it)
- ADDR_W, 12, request address width
- BUS_W, 17, core write-bus width; only bits [DATA_W-1:0] are stored
- DATA_W, 12, stored/returned word width
- DEPTH, 4096, words in the array; addresses >= DEPTH are out of range
- NTAP, 16, low words mirrored to debug taps

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NCORE  per-core request; held high with fields stable until granted
- we  in  NCORE  per-core write enable (1 = write, 0 = read)
- addr  in  NCORE*ADDR_W  per-core address, core i at [i*ADDR_W +: ADDR_W]
- wdata  in  NCORE*BUS_W  per-core write data
- gnt  out  NCORE  one-hot grant, combinational in the request cycle
- rvalid  out  NCORE  one-hot read-data valid, registered
- rdata  out  DATA_W  read data, valid when any rvalid bit is high
- taps  out  NTAP*DATA_W  words 0..NTAP-1, word k at [k*DATA_W +: DATA_W]

## Operation

- Arbitration is round-robin. The priority pointer `ptr` (2 bits) names the highest-priority core. Search order is ptr, ptr+1, … mod 4.
- Only one access is granted per cycle. `gnt` is zero when `req` is zero.
- On grant to core g: `ptr` <= g+1 mod 4 at the clock edge. `ptr` is unchanged when there is no grant.
- Granted write, in range: `mem[addr] <= wdata[DATA_W-1:0]` at the edge.
  - If addr < NTAP, the tap register is written instead of, or also beside, the array. The taps are the architectural copy for those words.
- Granted read: address is captured at the edge. The next cycle has `rvalid[g]=1` and `rdata` = stored word.
  - Reads with addr < NTAP return the tap register.
- Out-of-range address (>= DEPTH): still granted. A write is discarded. A read returns `rvalid` with `rdata=0`.
- The core may deassert `req` in the cycle after `gnt` or issue a new request immediately. A held `req` after grant is treated as a new request.
- Words NTAP..DEPTH-1 are not reset (contents undefined until written). Tap registers reset to 0.
- Storage uses a read-first single-port array. Read and write to the same word cannot coincide because there is one access per cycle.

## Timing

- Reset values: `ptr`=0, `rvalid`=0, `rdata`=0, all taps=0. `gnt` is combinational, so it follows `req` even during reset but is gated to 0 while `rst`=1.
- Grant latency: 0 cycles (same cycle as `req`, when winning).
- Worst-case wait for a continuously requesting core: 3 cycles before grant.
- Read latency: data and `rvalid` appear 1 cycle after the grant cycle, as a single-cycle pulse. `rdata` holds its last value when `rvalid`=0.
- Write visibility: a read granted in the cycle after a write to the same address returns the new value.
- Reset asserted mid-operation clears a pending read (`rvalid` is not asserted afterward) and discards the write of the current cycle. Requests are re-arbitrated from `ptr`=0 after release.
- Throughput: 1 access/cycle aggregate. All four requesting gives a grant sequence 0,1,2,3,0…

## Structure

- Package `dmem_pkg`: NCORE, ADDR_W, BUS_W, DATA_W, DEPTH, NTAP constants, and a `core_idx_t` 2-bit index type.
- Sub-module `rr_arbiter4`: inputs `req` and `ptr`, outputs one-hot `gnt` and an encoded winner index. It is purely combinational; `ptr` is held in the parent.
- The parent holds `ptr`, the array, the tap registers, the read-return register, and the `rvalid` pipeline (winner index and valid flag).

## Test plan

- Reset then single read: `req`=0001, `we`=0, addr=5 → `gnt`=0001 same cycle; next cycle `rvalid`=0001, `rdata`=0.
- Write then read: core 2 writes 0x1ABC to addr 3 → taps word 3 = 0xABC. Core 0 reads addr 3 the next cycle → `rdata`=0xABC.
- Fairness: `req`=1111 held 8 cycles, all reads → grants 0,1,2,3,0,1,2,3. `ptr` after the last grant = 0.
- Pointer skip: `ptr`=2, `req`=0011 → `gnt`=0001; next cycle (`req`=0011) → `gnt`=0010.
- Out of range: DEPTH=64, core 1 writes 0x555 to addr 100 → `gnt`=0010, no tap/array change; a read of addr 100 → `rvalid`=0010, `rdata`=0.
- Reset mid-read: grant a read to core 3 and assert `rst` before the next edge → `rvalid` stays 0, `ptr`=0, taps=0.
